// File: rtl/cache_pkg.sv
// Shared types and default geometry for the n-way cache controller.
package cache_pkg;

    localparam int DEF_NUM_WAYS = 4;
    localparam int DEF_NUM_SETS = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EVICT = 2'd1,
        FILL  = 2'd2
    } state_e;

endpackage

// File: rtl/plru_tree.sv
// Per-set tree pseudo-LRU: storage, victim walk and access update.
// Node 0 is the root; children of node n are 2n+1 (left) and 2n+2 (right).
module plru_tree #(
    parameter int NUM_WAYS = 4,
    parameter int NUM_SETS = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [$clog2(NUM_SETS)-1:0] set_idx,
    input  logic                        update,
    input  logic [$clog2(NUM_WAYS)-1:0] update_way,
    output logic [$clog2(NUM_WAYS)-1:0] victim
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);
    localparam int NODE_W   = WAY_BITS + 1;

    logic [NUM_WAYS-2:0] plru_q [NUM_SETS];
    logic [NUM_WAYS-2:0] plru_d [NUM_SETS];

    // Victim walk: a 0 bit steers left, a 1 bit steers right.
    always_comb begin
        logic [NUM_WAYS-2:0] row;
        logic [NODE_W-1:0]   node;
        logic                bit_val;
        row  = plru_q[set_idx];
        node = '0;
        for (int l = 0; l < WAY_BITS; l++) begin
            bit_val = 1'b0;
            for (int k = 0; k < NUM_WAYS - 1; k++) begin
                if (node == NODE_W'(k)) begin
                    bit_val = row[k];
                end
            end
            node = (node << 1) + NODE_W'(1) + NODE_W'(bit_val);
        end
        victim = WAY_BITS'(node - NODE_W'(NUM_WAYS - 1));
    end

    // Access update: every node on the path to update_way points away from it.
    always_comb begin
        logic [NUM_WAYS-2:0] row;
        logic [NODE_W-1:0]   node;
        logic [WAY_BITS-1:0] sh;
        logic                dir;
        row  = plru_q[set_idx];
        node = '0;
        sh   = update_way;
        for (int l = 0; l < WAY_BITS; l++) begin
            dir = sh[WAY_BITS-1];
            for (int k = 0; k < NUM_WAYS - 1; k++) begin
                if (node == NODE_W'(k)) begin
                    row[k] = ~dir;
                end
            end
            node = (node << 1) + NODE_W'(1) + NODE_W'(dir);
            sh   = sh << 1;
        end
        plru_d = plru_q;
        if (update) begin
            plru_d[set_idx] = row;
        end
    end

    // PLRU storage; cleared to all-zero on reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < NUM_SETS; s++) begin
                plru_q[s] <= '0;
            end
        end else begin
            plru_q <= plru_d;
        end
    end

endmodule

// File: rtl/cache_control_nway.sv
// Control FSM for an n-way set-associative write-back cache.
// Hits complete in one cycle; misses optionally write back a dirty victim,
// then fill the line and return to IDLE where the request replays as a hit.
module cache_control_nway
    import cache_pkg::*;
#(
    parameter int NUM_WAYS = DEF_NUM_WAYS,
    parameter int NUM_SETS = DEF_NUM_SETS
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        mem_read,
    input  logic                        mem_write,
    input  logic [$clog2(NUM_SETS)-1:0] set_idx,
    input  logic [NUM_WAYS-1:0]         hit_vec,
    input  logic [NUM_WAYS-1:0]         valid_vec,
    input  logic [NUM_WAYS-1:0]         dirty_vec,
    input  logic                        pmem_resp,
    output logic                        mem_resp,
    output logic                        pmem_read,
    output logic                        pmem_write,
    output logic                        datainmux_sel,
    output logic                        addressmux_sel,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-1:0]         data_we,
    output logic [NUM_WAYS-1:0]         tag_we,
    output logic [NUM_WAYS-1:0]         valid_we,
    output logic [NUM_WAYS-1:0]         dirty_we,
    output logic                        dirty_in
);

    localparam int WAY_BITS = $clog2(NUM_WAYS);

    state_e              state_q, state_d;
    logic [WAY_BITS-1:0] victim_way_q, victim_way_d;

    logic [WAY_BITS-1:0] plru_victim;
    logic [WAY_BITS-1:0] hit_way;
    logic [WAY_BITS-1:0] inv_way;
    logic [WAY_BITS-1:0] sel_way;
    logic                has_inv;
    logic                plru_update;
    logic [NUM_WAYS-1:0] victim_onehot;

    plru_tree #(
        .NUM_WAYS (NUM_WAYS),
        .NUM_SETS (NUM_SETS)
    ) u_plru (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_idx    (set_idx),
        .update     (plru_update),
        .update_way (hit_way),
        .victim     (plru_victim)
    );

    // Encode the hit way and the lowest-index invalid way; an invalid way
    // is always preferred over the PLRU choice.
    always_comb begin
        hit_way = '0;
        inv_way = '0;
        for (int i = NUM_WAYS - 1; i >= 0; i--) begin
            if (hit_vec[i]) begin
                hit_way = WAY_BITS'(i);
            end
            if (!valid_vec[i]) begin
                inv_way = WAY_BITS'(i);
            end
        end
        has_inv       = ~&valid_vec;
        sel_way       = has_inv ? inv_way : plru_victim;
        victim_onehot = NUM_WAYS'(1) << victim_way_q;
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        victim_way_d   = victim_way_q;
        plru_update    = 1'b0;
        mem_resp       = 1'b0;
        pmem_read      = 1'b0;
        pmem_write     = 1'b0;
        datainmux_sel  = 1'b0;
        addressmux_sel = 1'b0;
        data_we        = '0;
        tag_we         = '0;
        valid_we       = '0;
        dirty_we       = '0;
        dirty_in       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (mem_read || mem_write) begin
                    if (|hit_vec) begin
                        mem_resp    = 1'b1;
                        plru_update = 1'b1;
                        // A simultaneous read and write is handled as a write.
                        if (mem_write) begin
                            data_we       = hit_vec;
                            dirty_we      = hit_vec;
                            datainmux_sel = 1'b1;
                            dirty_in      = 1'b1;
                        end
                    end else begin
                        victim_way_d = sel_way;
                        if (valid_vec[sel_way] && dirty_vec[sel_way]) begin
                            state_d = EVICT;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            EVICT: begin
                pmem_write     = 1'b1;
                addressmux_sel = 1'b1;
                if (pmem_resp) begin
                    state_d = FILL;
                end
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    data_we  = victim_onehot;
                    tag_we   = victim_onehot;
                    valid_we = victim_onehot;
                    dirty_we = victim_onehot;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and victim registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            victim_way_q <= '0;
        end else begin
            state_q      <= state_d;
            victim_way_q <= victim_way_d;
        end
    end

    assign victim_way = victim_way_q;

endmodule

// File: tb/tb_cache_control_nway.sv
// Directed scoreboard bench for cache_control_nway (4 ways, 8 sets).
module tb_cache_control_nway;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       mem_read, mem_write;
    logic [2:0] set_idx;
    logic [3:0] hit_vec, valid_vec, dirty_vec;
    logic       pmem_resp;
    logic       mem_resp, pmem_read, pmem_write, datainmux_sel, addressmux_sel;
    logic [1:0] victim_way;
    logic [3:0] data_we, tag_we, valid_we, dirty_we;
    logic       dirty_in;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       name;
        logic [23:0] outv;
        bit          chk_plru;
        int          pset;
        logic [2:0]  pexp;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    cache_control_nway #(.NUM_WAYS(4), .NUM_SETS(8)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .set_idx        (set_idx),
        .hit_vec        (hit_vec),
        .valid_vec      (valid_vec),
        .dirty_vec      (dirty_vec),
        .pmem_resp      (pmem_resp),
        .mem_resp       (mem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .datainmux_sel  (datainmux_sel),
        .addressmux_sel (addressmux_sel),
        .victim_way     (victim_way),
        .data_we        (data_we),
        .tag_we         (tag_we),
        .valid_we       (valid_we),
        .dirty_we       (dirty_we),
        .dirty_in       (dirty_in)
    );

    // Output vector layout: {mem_resp, pmem_read, pmem_write, datainmux_sel,
    // addressmux_sel, dirty_in, victim_way[1:0], data_we, tag_we, valid_we, dirty_we}
    function automatic logic [23:0] ov(bit mr, bit pr, bit pw, bit ds, bit as, bit di,
                                       logic [1:0] vw, logic [3:0] dwe, logic [3:0] twe,
                                       logic [3:0] vwe, logic [3:0] ywe);
        return {mr, pr, pw, ds, as, di, vw, dwe, twe, vwe, ywe};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic push(string n, logic [23:0] v);
        exp_t e;
        e.name = n; e.outv = v; e.chk_plru = 1'b0; e.pset = 0; e.pexp = '0;
        exp_q.push_back(e);
    endtask

    task automatic push_p(string n, logic [23:0] v, int s, logic [2:0] p);
        exp_t e;
        e.name = n; e.outv = v; e.chk_plru = 1'b1; e.pset = s; e.pexp = p;
        exp_q.push_back(e);
    endtask

    task automatic drive(bit rd, bit wr, logic [2:0] s, logic [3:0] h,
                         logic [3:0] v, logic [3:0] d, bit pr);
        mem_read = rd; mem_write = wr; set_idx = s; hit_vec = h;
        valid_vec = v; dirty_vec = d; pmem_resp = pr;
    endtask

    // Monitor: compares the DUT against the oldest pending expectation
    // on the falling edge of each cycle that has one.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t        e;
            logic [23:0] act;
            logic [2:0]  pact;
            e   = exp_q.pop_front();
            act = {mem_resp, pmem_read, pmem_write, datainmux_sel, addressmux_sel, dirty_in,
                   victim_way, data_we, tag_we, valid_we, dirty_we};
            total++;
            if (act !== e.outv) begin
                bad++;
                $display("FAIL %s: outputs got=%h want=%h", e.name, act, e.outv);
            end
            if (e.chk_plru) begin
                pact = dut.u_plru.plru_q[e.pset];
                total++;
                if (pact !== e.pexp) begin
                    bad++;
                    $display("FAIL %s: plru[%0d] got=%b want=%b", e.name, e.pset, pact, e.pexp);
                end
            end
        end
    end

    localparam logic [23:0] ZERO = 24'h0;

    initial begin
        rst_n = 1'b0;
        drive(0, 0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        push_p("reset_state", ZERO, 3, 3'b000);

        // Read hit set 3 way 2: single-cycle response, PLRU root=0 node2=1.
        cyc(); drive(1, 0, 3'd3, 4'b0100, 4'b1111, 4'b0000, 0);
        push("rd_hit_s3", ov(1,0,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); drive(0, 0, 3'd3, 4'b0000, 4'b1111, 4'b0000, 0);
        push_p("rd_hit_s3_plru", ZERO, 3, 3'b100);

        // Clean read miss on set 0: victim 0, FILL for 5 cycles.
        cyc(); drive(1, 0, 3'd0, 4'b0000, 4'b1111, 4'b0000, 0);
        push("rd_miss_idle", ZERO);
        for (int i = 0; i < 4; i++) begin
            cyc();
            push("fill_wait", ov(0,1,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        end
        cyc(); pmem_resp = 1'b1;
        push("fill_done", ov(0,1,0,0,0,0, 2'd0, 4'h1,4'h1,4'h1,4'h1));
        cyc(); drive(1, 0, 3'd0, 4'b0001, 4'b1111, 4'b0000, 0);
        push("rd_replay_hit", ov(1,0,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); drive(0, 0, 3'd0, 4'b0000, 4'b1111, 4'b0000, 0);
        push("idle_after_rd", ZERO);

        // Dirty write miss on set 1: EVICT, FILL, replay write hit.
        cyc(); drive(0, 1, 3'd1, 4'b0000, 4'b1111, 4'b0001, 0);
        push("wr_miss_idle", ZERO);
        cyc();
        push("evict_wait", ov(0,0,1,0,1,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); pmem_resp = 1'b1;
        push("evict_done", ov(0,0,1,0,1,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); pmem_resp = 1'b0;
        push("wb_fill_wait", ov(0,1,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); pmem_resp = 1'b1;
        push("wb_fill_done", ov(0,1,0,0,0,0, 2'd0, 4'h1,4'h1,4'h1,4'h1));
        cyc(); drive(0, 1, 3'd1, 4'b0001, 4'b1111, 4'b0000, 0);
        push("wr_replay_hit", ov(1,0,0,1,0,1, 2'd0, 4'h1,4'h0,4'h0,4'h1));

        // Read+write together on a hit behaves as a write; PLRU set 5 for way 1.
        cyc(); drive(1, 1, 3'd5, 4'b0010, 4'b1111, 4'b0000, 0);
        push("rdwr_hit", ov(1,0,0,1,0,1, 2'd0, 4'h2,4'h0,4'h0,4'h2));
        // Stray pmem_resp in IDLE is ignored.
        cyc(); drive(0, 0, 3'd5, 4'b0000, 4'b1111, 4'b0000, 1);
        push_p("stray_pmem_resp", ZERO, 5, 3'b001);
        cyc(); pmem_resp = 1'b0;
        push("stray_pmem_after", ZERO);

        // Set 4 with way 2 invalid: invalid way wins, no EVICT despite dirty bits.
        cyc(); drive(1, 0, 3'd4, 4'b0000, 4'b1011, 4'b1111, 0);
        push("inv_miss_idle", ZERO);
        cyc();
        rst_n = 1'b0;
        push("inv_fill", ov(0,1,0,0,0,0, 2'd2, 4'h0,4'h0,4'h0,4'h0));
        // Reset lands mid-FILL: transaction abandoned, victim cleared.
        cyc(); rst_n = 1'b1; drive(0, 0, 3'd4, 4'b0000, 4'b1011, 4'b1111, 0);
        push("rst_mid_fill", ZERO);
        cyc(); pmem_resp = 1'b1;
        push("rst_idle_hold", ZERO);

        // Hits on ways 0..3 of set 2 leave the PLRU pointing at way 0.
        for (int w = 0; w < 4; w++) begin
            cyc(); drive(1, 0, 3'd2, 4'(1 << w), 4'b1111, 4'b0000, 0);
            push("seq_hit_s2", ov(1,0,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        end
        cyc(); drive(0, 0, 3'd2, 4'b0000, 4'b1111, 4'b0000, 0);
        push_p("seq_hit_plru", ZERO, 2, 3'b000);
        cyc(); drive(1, 0, 3'd2, 4'b0000, 4'b1111, 4'b0000, 0);
        push("seq_miss_idle", ZERO);
        cyc(); pmem_resp = 1'b1;
        push("seq_fill_done", ov(0,1,0,0,0,0, 2'd0, 4'h1,4'h1,4'h1,4'h1));

        // Set 6: touching way 0 makes the PLRU victim way 2.
        cyc(); drive(1, 0, 3'd6, 4'b0001, 4'b1111, 4'b0000, 0);
        push("s6_hit_w0", ov(1,0,0,0,0,0, 2'd0, 4'h0,4'h0,4'h0,4'h0));
        cyc(); drive(1, 0, 3'd6, 4'b0000, 4'b1111, 4'b0000, 0);
        push_p("s6_miss_idle", ZERO, 6, 3'b011);
        cyc(); pmem_resp = 1'b1;
        push("s6_fill_done", ov(0,1,0,0,0,0, 2'd2, 4'h4,4'h4,4'h4,4'h4));
        cyc(); drive(1, 0, 3'd6, 4'b0100, 4'b1111, 4'b0000, 0);
        push("s6_replay_hit", ov(1,0,0,0,0,0, 2'd2, 4'h0,4'h0,4'h0,4'h0));
        cyc(); drive(0, 0, 3'd0, 4'b0000, 4'b0000, 4'b0000, 0);
        push("final_idle", ov(0,0,0,0,0,0, 2'd2, 4'h0,4'h0,4'h0,4'h0));

        cyc();
        cyc();
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: pending=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
